mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory/request address width.
REQ-002 SHALL have ports:
- clk_in  input  1  system clock; all state on rising edge
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global ready; low = pause
- if_req_i  input  1  fetch request, held until if_done_o
- if_addr_i  input  ADDR_WIDTH  fetch address
- if_data_o  output  32  fetched instruction word
- if_done_o  output  1  one-cycle fetch completion pulse
- ls_req_i  input  1  load/store request, held until ls_done_o
- ls_we_i  input  1  1 = store, 0 = load
- ls_len_i  input  2  bytes-1: 0 byte, 1 half, 3 word (2 unused)
- ls_addr_i  input  ADDR_WIDTH  load/store address
- ls_wdata_i  input  32  store data, low bytes used
- ls_data_o  output  32  load data, zero-extended
- ls_done_o  output  1  one-cycle load/store completion pulse
- mem_din  input  8  RAM/IO read byte
- mem_dout  output  8  RAM/IO write byte
- mem_addr  output  ADDR_WIDTH  RAM/IO byte address
- mem_wr  output  1  1 = write cycle

Function
REQ-003 SHALL arbitrate the single byte-wide port between fetch and load/store; FSM states IDLE, READ, WRITE.
REQ-004 SHALL, in IDLE with both requests high, accept ls; accept if only when ls_req_i low.
REQ-005 SHALL ignore requests in the cycle its own done pulse is high; next acceptance earliest the following cycle.
REQ-006 SHALL latch address, length, wdata and requester at acceptance; later request-input changes have no effect until done.
REQ-007 Fetch SHALL always be a 4-byte read.
REQ-008 READ: acceptance cycle T; byte k address (base+k) on mem_addr in cycle T+1+k; mem_din sampled one cycle later; n bytes -> done pulse at cycle T+n+2.
REQ-009 Byte order SHALL be little-endian: byte k -> data bits [8k+7:8k]; unfetched bytes zero.
REQ-010 WRITE: byte k of ls_wdata_i on mem_dout, address base+k, mem_wr=1 in cycle T+1+k; ls_done_o at cycle T+n+1.
REQ-011 Address arithmetic SHALL be ADDR_WIDTH-bit modulo; no alignment check; base+k wraps at 2^ADDR_WIDTH.
REQ-012 if_data_o/ls_data_o SHALL hold their value from the done pulse until the next completion for that requester.
REQ-013 In IDLE, mem_addr=0, mem_wr=0, mem_dout=0 (never idle-read 0x30000 I/O, avoiding input-byte consumption).
REQ-014 With rdy_in low: FSM, counters, captured bytes frozen; mem_wr forced 0; mem_addr held; no mem_din sample; done pulses deferred.
REQ-015 On rdy_in return high, SHALL re-present the held address and resume, preserving REQ-008/010 relative order; pause of P cycles delays done by exactly P cycles.
REQ-016 I/O addresses (bits[17:16]==2'b11) SHALL be handled identically to RAM; no speculative or repeated access beyond REQ-015.

Reset
REQ-017 rst_in high at a clock edge SHALL force IDLE, counters 0, mem_addr=0, mem_dout=0, mem_wr=0, done outputs 0, data outputs 0.
REQ-018 Reset mid-transaction SHALL abandon it with no done pulse; rst_in has priority over rdy_in.

Structure
REQ-019 FSM state encoding, length codes, I/O address-select constant SHALL live in the shared defines file.
REQ-020 SHALL be one module, no sub-module; cpu top instantiates it between pc_reg/if_id and mem stage, driving mem_addr/mem_dout/mem_wr.

Verification
REQ-021 Fetch 0x0000_0010, RAM bytes 13,00,00,93 -> if_data_o=0x9300_0013, if_done_o 6 cycles after acceptance.
REQ-022 if and ls (load byte 0x100, RAM 0xAB) same cycle -> ls first, ls_data_o=0x0000_00AB at T+3; fetch accepted the cycle after ls_done_o.
REQ-023 Store word 0xDEADBEEF at 0x200 -> mem_wr high 4 cycles, addresses 0x200..0x203, data EF,BE,AD,DE, ls_done_o at T+5.
REQ-024 rdy_in low 3 cycles during byte 2 of word store -> no duplicate mem_wr; 4 write cycles total; done at T+8.
REQ-025 rst_in high during word load byte 1 -> next cycle IDLE, mem_addr=0, no ls_done_o; new fetch then completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: FSM encoding, length codes and I/O select constant shared by the memory controller
package mem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;
   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd3;
   localparam logic [1:0] IO_SEL = 2'b11;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide RAM/IO port between instruction fetch and load/store
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic [31:0]           if_data_o,
   output logic                  if_done_o,
   input  logic                  ls_req_i,
   input  logic                  ls_we_i,
   input  logic [1:0]            ls_len_i,
   input  logic [ADDR_WIDTH-1:0] ls_addr_i,
   input  logic [31:0]           ls_wdata_i,
   output logic [31:0]           ls_data_o,
   output logic                  ls_done_o,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wr
);
   state_t state, state_n;
   logic [2:0] cnt, n;
   logic [1:0] len;
   logic src_ls, accept, fin, live;
   logic [ADDR_WIDTH-1:0] base, last_addr, cur_addr;
   logic [31:0] wdata, buf_q, buf_n, wsh;
   assign n = {1'b0, len} + 3'd1;
   assign cur_addr = base + ADDR_WIDTH'(cnt);
   assign accept = state == IDLE && rdy_in && !if_done_o && !ls_done_o && (ls_req_i || if_req_i);
   assign fin = rdy_in && ((state == READ && cnt == n) || (state == WRITE && cnt == n - 3'd1));
   assign live = (state == READ && cnt < n) || state == WRITE;
   assign wsh = wdata >> {cnt[1:0], 3'b000};
   // During a pause the previous cycle's address stays on the bus, so the byte a synchronous
   // RAM returns on resume is still the one the interrupted sample expects.
   assign mem_addr = state == IDLE ? '0 : !rdy_in ? last_addr : live ? cur_addr : '0;
   assign mem_wr = state == WRITE && rdy_in;
   assign mem_dout = state == WRITE ? wsh[7:0] : 8'd0;
   always_comb begin
      buf_n = buf_q;
      buf_n[{cnt[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
   end
   always_comb begin
      state_n = state;
      if (accept) state_n = ls_req_i && ls_we_i ? WRITE : READ;
      else if (fin) state_n = IDLE;
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         cnt <= '0;
         len <= '0;
         src_ls <= 1'b0;
         base <= '0;
         last_addr <= '0;
         wdata <= '0;
         buf_q <= '0;
         if_data_o <= '0;
         ls_data_o <= '0;
         if_done_o <= 1'b0;
         ls_done_o <= 1'b0;
      end else begin
         state <= state_n;
         last_addr <= mem_addr;
         if_done_o <= 1'b0;
         ls_done_o <= 1'b0;
         if (accept) begin
            base <= ls_req_i ? ls_addr_i : if_addr_i;
            len <= ls_req_i ? ls_len_i : LEN_WORD;
            src_ls <= ls_req_i;
            wdata <= ls_wdata_i;
            cnt <= '0;
            buf_q <= '0;
         end else if (rdy_in && state != IDLE) begin
            cnt <= cnt + 3'd1;
            if (state == READ && cnt != 3'd0) buf_q <= buf_n;
            if (fin) begin
               ls_done_o <= src_ls;
               if_done_o <= !src_ls;
               if (state == READ && src_ls) ls_data_o <= buf_n;
               if (state == READ && !src_ls) if_data_o <= buf_n;
            end
         end
      end
   end
endmodule
